// File: rtl/mux_lane_scheduler.sv
// Round-robin scheduler: four 9-bit lanes, each buffered in a small FIFO, share one
// registered output stage with ready/valid backpressure and sticky overflow flags.
module mux_lane_scheduler #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [8:0] data0,
    input  logic [8:0] data1,
    input  logic [8:0] data2,
    input  logic [8:0] data3,
    input  logic       out_ready,
    output logic [8:0] data_out,
    output logic [1:0] grant,
    output logic [3:0] lane_full,
    output logic [3:0] overflow
);
    localparam int NUM_LANES = 4;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [8:0]           lane_in [NUM_LANES];
    logic [7:0]           head [NUM_LANES];
    logic [NUM_LANES-1:0] non_empty;
    logic [NUM_LANES-1:0] push;
    logic [NUM_LANES-1:0] pop;
    logic [NUM_LANES-1:0] full_flag;
    logic [NUM_LANES-1:0] overflow_flag;

    logic [8:0] data_out_reg;
    logic [1:0] grant_reg;
    logic [1:0] last_grant_reg;
    logic       slot_free;
    logic       pop_found;
    logic [1:0] pop_lane;
    logic [1:0] scan_idx;

    assign lane_in[0] = data0;
    assign lane_in[1] = data1;
    assign lane_in[2] = data2;
    assign lane_in[3] = data3;

    assign slot_free = !data_out_reg[8] || out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0]       mem_reg [DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [PTR_W:0]   count_reg;
            logic             overflow_reg;

            assign non_empty[gi]     = (count_reg != '0);
            assign full_flag[gi]     = (count_reg == FULL_COUNT);
            assign pop[gi]           = slot_free && pop_found && (pop_lane == 2'(gi));
            // A full lane still accepts a word when its head leaves on the same edge.
            assign push[gi]          = lane_in[gi][8] && (!full_flag[gi] || pop[gi]);
            assign head[gi]          = mem_reg[rd_ptr_reg];
            assign overflow_flag[gi] = overflow_reg;

            always_ff @(posedge clk_4f) begin
                if (push[gi]) begin
                    mem_reg[wr_ptr_reg] <= lane_in[gi][7:0];
                end
            end

            always_ff @(posedge clk_4f) begin
                if (!reset) begin
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    count_reg    <= '0;
                    overflow_reg <= 1'b0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    count_reg <= count_reg + (PTR_W + 1)'(push[gi]) - (PTR_W + 1)'(pop[gi]);
                    if (lane_in[gi][8] && !push[gi]) begin
                        overflow_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Scan starts one past the last winner so every non-empty lane is reached within 4 pops.
    always_comb begin
        pop_found = 1'b0;
        pop_lane  = last_grant_reg;
        scan_idx  = last_grant_reg;
        for (int i = 1; i <= NUM_LANES; i++) begin
            scan_idx = last_grant_reg + 2'(i);
            if (!pop_found && non_empty[scan_idx]) begin
                pop_found = 1'b1;
                pop_lane  = scan_idx;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            data_out_reg   <= 9'h000;
            grant_reg      <= 2'd0;
            last_grant_reg <= 2'd3;
        end else if (slot_free) begin
            if (pop_found) begin
                data_out_reg   <= {1'b1, head[pop_lane]};
                grant_reg      <= pop_lane;
                last_grant_reg <= pop_lane;
            end else begin
                data_out_reg <= 9'h000;
            end
        end
    end

    assign data_out  = data_out_reg;
    assign grant     = grant_reg;
    assign lane_full = full_flag;
    assign overflow  = overflow_flag;
endmodule

// File: tb/tb_mux_lane_scheduler.sv
// Bench for mux_lane_scheduler: a per-cycle vector table for the simple cases and a
// scoreboard of expected output words for the backpressure, fairness and reset sequences.
module tb_mux_lane_scheduler;
    logic       clk_4f;
    logic       reset;
    logic [8:0] data0, data1, data2, data3;
    logic       out_ready;
    logic [8:0] data_out;
    logic [1:0] grant;
    logic [3:0] lane_full;
    logic [3:0] overflow;

    mux_lane_scheduler #(.DEPTH(4), .PTR_W(2)) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .out_ready (out_ready),
        .data_out  (data_out),
        .grant     (grant),
        .lane_full (lane_full),
        .overflow  (overflow)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic       rst_n;
        logic [8:0] d0, d1, d2, d3;
        logic       rdy;
        logic [8:0] e_dout;
        logic [1:0] e_grant;
        logic [3:0] e_full;
        logic [3:0] e_ovf;
    } vec_t;

    typedef struct {
        logic [8:0] d;
        logic [1:0] g;
    } exp_t;

    localparam int NUM_VECS = 15;
    vec_t vecs [NUM_VECS];
    exp_t sb [$];
    bit   sb_on;
    int   n_checks;
    int   n_fail;

    function automatic vec_t mk(logic rst_n, logic [8:0] d0, logic [8:0] d1, logic [8:0] d2,
                                logic [8:0] d3, logic rdy, logic [8:0] e_dout,
                                logic [1:0] e_grant, logic [3:0] e_full, logic [3:0] e_ovf);
        vec_t v;
        v.rst_n = rst_n; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.rdy = rdy;
        v.e_dout = e_dout; v.e_grant = e_grant; v.e_full = e_full; v.e_ovf = e_ovf;
        return v;
    endfunction

    function automatic exp_t ex(logic [8:0] d, logic [1:0] g);
        exp_t e;
        e.d = d;
        e.g = g;
        return e;
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic set_in(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c,
                          input logic [8:0] d, input logic rdy);
        data0 = a; data1 = b; data2 = c; data3 = d; out_ready = rdy;
    endtask

    // One clock edge; a word that loads into a free slot is matched against the scoreboard.
    task automatic tick();
        logic was_free;
        logic rst_at_edge;
        exp_t e;
        was_free    = !data_out[8] || out_ready;
        rst_at_edge = reset;
        @(posedge clk_4f);
        #1;
        if (sb_on && rst_at_edge && was_free && data_out[8]) begin
            $display("xfer data_out=%h grant=%0d", data_out, grant);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h, required no word", data_out);
            end else begin
                e = sb.pop_front();
                check("sb_data", data_out, e.d);
                check("sb_grant", 9'(grant), 9'(e.g));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_in(9'h0, 9'h0, 9'h0, 9'h0, 1'b1);
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            tick();
        end
        check(name, 9'(sb.size()), 9'd0);
    endtask

    // Lane 2 pushes 0x10..0x15 with the output blocked: 0x10 parks in data_out, 0x11..0x14 fill the FIFO.
    task automatic fill_lane2();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data2 = {1'b1, 8'h10 + 8'(i)};
            tick();
            if (i == 4) begin
                check("t4_full_before_drop", 9'(lane_full), 9'h004);
                check("t4_ovf_before_drop", 9'(overflow), 9'h000);
            end
        end
        data2 = 9'h0;
        check("t4_hold_dout", data_out, 9'h110);
        check("t4_hold_grant", 9'(grant), 9'd2);
        check("t4_full", 9'(lane_full), 9'h004);
        check("t4_ovf", 9'(overflow), 9'h004);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sb_on    = 1'b0;
        reset    = 1'b0;
        set_in(9'h0, 9'h0, 9'h0, 9'h0, 1'b0);

        // reset with lane 0 active, release, single word latency, re-reset, four-lane burst
        vecs[0]  = mk(1'b0, 9'h1AA, 9'h0, 9'h0, 9'h0, 1'b0, 9'h000, 2'd0, 4'h0, 4'h0);
        vecs[1]  = mk(1'b0, 9'h1AA, 9'h0, 9'h0, 9'h0, 1'b0, 9'h000, 2'd0, 4'h0, 4'h0);
        vecs[2]  = mk(1'b0, 9'h1AA, 9'h0, 9'h0, 9'h0, 1'b0, 9'h000, 2'd0, 4'h0, 4'h0);
        vecs[3]  = mk(1'b1, 9'h000, 9'h0, 9'h0, 9'h0, 1'b1, 9'h000, 2'd0, 4'h0, 4'h0);
        vecs[4]  = mk(1'b1, 9'h000, 9'h0, 9'h0, 9'h0, 1'b1, 9'h000, 2'd0, 4'h0, 4'h0);
        vecs[5]  = mk(1'b1, 9'h155, 9'h0, 9'h0, 9'h0, 1'b1, 9'h000, 2'd0, 4'h0, 4'h0);
        vecs[6]  = mk(1'b1, 9'h000, 9'h0, 9'h0, 9'h0, 1'b1, 9'h155, 2'd0, 4'h0, 4'h0);
        vecs[7]  = mk(1'b1, 9'h000, 9'h0, 9'h0, 9'h0, 1'b1, 9'h000, 2'd0, 4'h0, 4'h0);
        vecs[8]  = mk(1'b0, 9'h000, 9'h0, 9'h0, 9'h0, 1'b1, 9'h000, 2'd0, 4'h0, 4'h0);
        vecs[9]  = mk(1'b1, 9'h101, 9'h102, 9'h103, 9'h104, 1'b1, 9'h000, 2'd0, 4'h0, 4'h0);
        vecs[10] = mk(1'b1, 9'h000, 9'h0, 9'h0, 9'h0, 1'b1, 9'h101, 2'd0, 4'h0, 4'h0);
        vecs[11] = mk(1'b1, 9'h000, 9'h0, 9'h0, 9'h0, 1'b1, 9'h102, 2'd1, 4'h0, 4'h0);
        vecs[12] = mk(1'b1, 9'h000, 9'h0, 9'h0, 9'h0, 1'b1, 9'h103, 2'd2, 4'h0, 4'h0);
        vecs[13] = mk(1'b1, 9'h000, 9'h0, 9'h0, 9'h0, 1'b1, 9'h104, 2'd3, 4'h0, 4'h0);
        vecs[14] = mk(1'b1, 9'h000, 9'h0, 9'h0, 9'h0, 1'b1, 9'h000, 2'd3, 4'h0, 4'h0);

        for (int i = 0; i < NUM_VECS; i++) begin
            reset = vecs[i].rst_n;
            set_in(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].rdy);
            tick();
            $display("vec %0d data_out=%h grant=%0d lane_full=%h overflow=%h",
                     i, data_out, grant, lane_full, overflow);
            check($sformatf("v%0d_dout", i), data_out, vecs[i].e_dout);
            check($sformatf("v%0d_grant", i), 9'(grant), 9'(vecs[i].e_grant));
            check($sformatf("v%0d_full", i), 9'(lane_full), 9'(vecs[i].e_full));
            check($sformatf("v%0d_ovf", i), 9'(overflow), 9'(vecs[i].e_ovf));
        end

        sb_on = 1'b1;

        // backpressure fill, drop on a full lane, then in-order drain with sticky overflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ex({1'b1, 8'h10 + 8'(i)}, 2'd2));
        end
        fill_lane2();
        out_ready = 1'b1;
        wait_drain("t4_drain");
        tick();
        check("t4_idle_dout", data_out, 9'h000);
        check("t4_full_after", 9'(lane_full), 9'h000);
        check("t4_ovf_sticky", 9'(overflow), 9'h004);

        // two busy lanes alternate without loss
        do_reset();
        for (int i = 0; i < 6; i++) begin
            sb.push_back(ex({1'b1, 8'h20 + 8'(i)}, 2'd0));
            sb.push_back(ex({1'b1, 8'h30 + 8'(i)}, 2'd3));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data0 = {1'b1, 8'h20 + 8'(i)};
            data3 = {1'b1, 8'h30 + 8'(i)};
            tick();
        end
        data0 = 9'h0;
        data3 = 9'h0;
        wait_drain("t5_drain");
        check("t5_ovf", 9'(overflow), 9'h000);

        // reset in the middle of a drain flushes everything
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ex({1'b1, 8'h10 + 8'(i)}, 2'd2));
        end
        fill_lane2();
        out_ready = 1'b1;
        tick();
        tick();
        check("t6_sb_before_reset", 9'(sb.size()), 9'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t6_rst_dout", data_out, 9'h000);
        check("t6_rst_grant", 9'(grant), 9'd0);
        check("t6_rst_full", 9'(lane_full), 9'h000);
        check("t6_rst_ovf", 9'(overflow), 9'h000);
        tick();
        check("t6_flushed", data_out, 9'h000);
        sb.push_back(ex(9'h177, 2'd1));
        data1 = 9'h177;
        tick();
        data1 = 9'h0;
        wait_drain("t6_drain");
        tick();
        check("t6_idle_dout", data_out, 9'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
